// File: rtl/ddr_burst_writer.sv
// ddr_burst_writer: drains 128-bit words from a FWFT word FIFO into DDR as
// AXI4 INCR write bursts over a circular region starting at base_addr.
// Optional build macro DDR_WR_FLUSH_EN: after FLUSH_CYCLES quiet idle cycles
// with a partial residue, issue a short burst of word_fifo_count beats.
module ddr_burst_writer #(
   parameter int ADDR_WIDTH   = 32,
   parameter int WORD_WIDTH   = 128,
   parameter int BURST_LEN    = 16,
   parameter int CNT_WIDTH    = 6,
   parameter int REGION_BYTES = 65536,
   parameter int FLUSH_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic                    word_fifo_empty,
   input  logic [CNT_WIDTH-1:0]    word_fifo_count,
   input  logic [WORD_WIDTH-1:0]   word_fifo_dout,
   output logic                    word_fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic [7:0]              m_awlen,
   output logic [2:0]              m_awsize,
   output logic [1:0]              m_awburst,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [WORD_WIDTH-1:0]   m_wdata,
   output logic [WORD_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wlast,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   output logic                    busy,
   output logic                    wr_err,
   output logic [15:0]             bursts_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AW   = 2'd1;
   localparam logic [1:0] ST_W    = 2'd2;
   localparam logic [1:0] ST_B    = 2'd3;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] offset;
   logic [7:0]            beat_cnt;
   logic                  full_ready;
   logic                  flush_go;
   logic                  start;
   logic                  beat;
   logic [ADDR_WIDTH-1:0] next_off;

   assign m_awsize        = 3'd4;
   assign m_awburst       = 2'b01;
   assign m_wstrb         = '1;
   assign m_wdata         = word_fifo_dout;
   assign m_wvalid        = (state == ST_W) && !word_fifo_empty;
   assign m_wlast         = (state == ST_W) && (beat_cnt == m_awlen);
   assign m_bready        = (state == ST_B);
   assign beat            = m_wvalid && m_wready;
   assign word_fifo_rd_en = beat;
   assign busy            = (state != ST_IDLE);

   assign full_ready = (32'(word_fifo_count) >= BURST_LEN);
   assign start      = (state == ST_IDLE) && enable && (full_ready || flush_go);

   // offset after the current burst; m_awlen holds len-1, so len*16 = awlen*16 + 16
   assign next_off = offset + ADDR_WIDTH'({m_awlen, 4'b0000}) + ADDR_WIDTH'(16);

`ifdef DDR_WR_FLUSH_EN
   localparam int IW = $clog2(FLUSH_CYCLES + 1);
   logic [IW-1:0]        idle_cnt;
   logic [CNT_WIDTH-1:0] last_count;

   assign flush_go = (idle_cnt == IW'(FLUSH_CYCLES)) && (word_fifo_count != '0);

   // count quiet idle cycles while only a partial burst's worth of words is held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt   <= '0;
         last_count <= '0;
      end else begin
         last_count <= word_fifo_count;
         if (state != ST_IDLE || start || word_fifo_count != last_count ||
             word_fifo_count == '0 || full_ready)
            idle_cnt <= '0;
         else if (idle_cnt != IW'(FLUSH_CYCLES))
            idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign flush_go = 1'b0;
`endif

   // burst sequencer: IDLE -> AW -> W -> B -> IDLE, one burst outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         offset      <= '0;
         beat_cnt    <= '0;
         m_awaddr    <= '0;
         m_awlen     <= '0;
         m_awvalid   <= 1'b0;
         wr_err      <= 1'b0;
         bursts_done <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  m_awaddr  <= base_addr + offset;
                  // full bursts take priority over a flush
                  m_awlen   <= full_ready ? 8'(BURST_LEN - 1) : 8'(word_fifo_count) - 8'd1;
                  m_awvalid <= 1'b1;
                  state     <= ST_AW;
               end
            end
            ST_AW: begin
               if (m_awready) begin
                  m_awvalid <= 1'b0;
                  beat_cnt  <= '0;
                  state     <= ST_W;
               end
            end
            ST_W: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (beat_cnt == m_awlen)
                     state <= ST_B;
               end
            end
            default: begin
               if (m_bvalid) begin
                  if (m_bresp != 2'b00)
                     wr_err <= 1'b1;
                  bursts_done <= bursts_done + 16'd1;
                  if (next_off + ADDR_WIDTH'(BURST_LEN * 16) > ADDR_WIDTH'(REGION_BYTES))
                     offset <= '0;
                  else
                     offset <= next_off;
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule
